// File: rtl/accel_host_pkg.sv
// Shared definitions for the accelerator host initiator: default sizing and
// the 2-bit FSM state encodings.
package accel_host_pkg;

  localparam int DEF_DATA_W  = 16;
  localparam int DEF_DEPTH   = 4;
  localparam int DEF_TIMEOUT = 64;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ISSUE = ST_ISSUE,
    WAIT  = ST_WAIT,
    RESP  = ST_RESP
  } state_e;

endpackage

// File: rtl/job_fifo.sv
// Circular job buffer; pointers carry one extra MSB so that full and empty
// are told apart without a separate occupancy counter.
module job_fifo
  import accel_host_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              do_push;
  logic              do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  // NOTE: non-blocking assignments for all clocked state so every register
  // samples the pre-edge value of its neighbours, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // NOTE: storage is not reset; an entry is only ever read after it has been
  // written, and leaving it out of reset keeps it a plain RAM array.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/accel_host.sv
// Host-side start/done initiator: queues jobs, issues one start pulse per
// job, waits for done or a timeout, and returns the result on valid/ready.
module accel_host
  import accel_host_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              acc_start,
  output logic [DATA_W-1:0] acc_data,
  input  logic              acc_done,
  input  logic [DATA_W-1:0] acc_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_timeout,
  output logic              busy
);

  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e            state;
  state_e            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              pop;
  logic              push;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_rdata;

  // Ready depends on the registered full flag only, never on this cycle's pop.
  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;
  assign busy     = (state != IDLE) || !fifo_empty;

  job_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_job_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (in_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: every output of this block gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    state_nxt = state;
    pop       = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT:  if (acc_done || (cnt == CNT_LAST)) state_nxt = RESP;
      RESP:  if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Start pulse and operand are registered on the pop, so they appear
  // together in the ISSUE cycle; done outside WAIT is never looked at.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_start   <= 1'b0;
      acc_data    <= '0;
      cnt         <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_timeout <= 1'b0;
    end else begin
      acc_start <= pop;
      if (pop) acc_data <= fifo_rdata;
      case (state)
        ISSUE: cnt <= '0;
        WAIT: begin
          if (acc_done) begin
            out_data    <= acc_result;
            out_timeout <= 1'b0;
            out_valid   <= 1'b1;
          end else if (cnt == CNT_LAST) begin
            out_data    <= '0;
            out_timeout <= 1'b1;
            out_valid   <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        RESP: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_accel_host.sv
// Bench for accel_host: a behavioural accelerator plus an in-order response
// scoreboard, driven by directed scenarios and a randomized job stream.
module tb_accel_host;

  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int TO    = 8;

  typedef struct {
    logic          to;
    logic [DW-1:0] data;
  } resp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          acc_start;
  logic [DW-1:0] acc_data;
  logic          acc_done = 1'b0;
  logic [DW-1:0] acc_result = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_timeout;
  logic          busy;

  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] exp_ops[$];
  resp_t         exp_resp[$];
  int            cd = 0;
  logic [DW-1:0] res = '0;
  int            acc_delay_cfg = 5;
  int            inject_cyc = -1;
  int            start_cnt = 0;
  int            last_start_cyc = -1;
  int            resp_cnt = 0;
  int            last_resp_cyc = -1;
  logic [DW-1:0] last_data = '0;
  logic          last_to = 1'b0;
  bit            rand_ready = 1'b0;
  bit            ready_fixed = 1'b0;
  int            acc_d;
  logic [DW-1:0] acc_op;
  resp_t         acc_e;
  resp_t         mon_e;

  accel_host #(
    .DATA_W  (DW),
    .DEPTH   (DEPTH),
    .TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .acc_start   (acc_start),
    .acc_data    (acc_data),
    .acc_done    (acc_done),
    .acc_result  (acc_result),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_timeout (out_timeout),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // What the accelerator computes for an operand.
  function automatic logic [DW-1:0] f_acc(input logic [DW-1:0] x);
    return x ^ 16'h1291;
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_job(input logic [DW-1:0] d);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        exp_ops.push_back(d);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("push_accept", 32'(ok), 1);
  endtask

  task automatic wait_resps(input int n, input int budget);
    for (int i = 0; i < budget && resp_cnt < n; i++) tick();
    check("resp_arrival", resp_cnt, n);
  endtask

  // Downstream ready: fixed level or random, changed away from the edge.
  always begin
    @(posedge clk);
    #2;
    out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_fixed;
  end

  // Accelerator: a done pulse d cycles after start; d in 1..TO lands inside
  // the WAIT window and yields a result, anything else yields a timeout.
  always @(negedge clk) begin
    if (acc_start) begin
      start_cnt++;
      last_start_cyc = cyc;
      check("start_has_job", 32'(exp_ops.size() != 0), 1);
      if (exp_ops.size() != 0) begin
        acc_op = exp_ops.pop_front();
        check("acc_data", acc_data, acc_op);
      end
      acc_d = (acc_delay_cfg < 0) ? int'($urandom_range(1, TO + 3)) : acc_delay_cfg;
      cd  = acc_d;
      res = f_acc(acc_data);
      acc_e.to   = !(acc_d >= 1 && acc_d <= TO);
      acc_e.data = acc_e.to ? '0 : f_acc(acc_data);
      exp_resp.push_back(acc_e);
    end
  end

  always begin
    @(posedge clk);
    #1;
    acc_done   = 1'b0;
    acc_result = DW'($urandom);
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        acc_done   = 1'b1;
        acc_result = res;
      end
    end
    if (cyc == inject_cyc) begin
      acc_done   = 1'b1;
      acc_result = 16'hDEAD;
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      resp_cnt++;
      last_resp_cyc = cyc;
      last_data     = out_data;
      last_to       = out_timeout;
      check("resp_expected", 32'(exp_resp.size() != 0), 1);
      if (exp_resp.size() != 0) begin
        mon_e = exp_resp.pop_front();
        check("resp_data", out_data, mon_e.data);
        check("resp_timeout", out_timeout, mon_e.to);
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] d;
    int t0, sc, rc;

    rst = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_ctrl", {acc_start, out_valid, out_timeout, busy}, 0);
    tick(3);
    rst = 1'b0;
    @(negedge clk);
    check("init_in_ready", in_ready, 1);
    check("init_ctrl", {acc_start, out_valid, out_timeout, busy}, 0);
    check("init_acc_data", acc_data, 0);
    check("init_out_data", out_data, 0);
    tick();

    // Single job: start in cycle 2, done at +5, response in cycle 8.
    ready_fixed = 1'b1;
    acc_delay_cfg = 5;
    sc = start_cnt; rc = resp_cnt; t0 = cyc;
    push_job(16'h00A5);
    wait_resps(rc + 1, 40);
    check("t1_starts", start_cnt - sc, 1);
    check("t1_start_cyc", last_start_cyc - t0, 2);
    check("t1_resp_cyc", last_resp_cyc - t0, 8);
    check("t1_data", last_data, 16'h1234);
    check("t1_timeout", last_to, 0);
    tick(2);

    // Five back-to-back jobs: 4 buffered + 1 popped leaves the FIFO full.
    acc_delay_cfg = 7;
    rc = resp_cnt; t0 = cyc;
    for (int i = 0; i < 5; i++) push_job(DW'($urandom));
    check("t2_back_to_back", cyc - t0, 5);
    @(negedge clk);
    check("t2_full_ready", in_ready, 0);
    check("t2_busy", busy, 1);
    tick();
    wait_resps(rc + 5, 400);
    tick(2);

    // Timeout, a stray done after it, then a normal job.
    acc_delay_cfg = 0;
    rc = resp_cnt; sc = start_cnt; t0 = cyc;
    inject_cyc = t0 + 12;
    push_job(DW'($urandom));
    wait_resps(rc + 1, 40);
    check("t3_resp_cyc", last_resp_cyc - t0, TO + 3);
    check("t3_timeout", last_to, 1);
    check("t3_data", last_data, 0);
    tick(5);
    check("t3_stray_resp", resp_cnt - rc, 1);
    check("t3_stray_start", start_cnt - sc, 1);
    check("t3_idle", busy, 0);
    acc_delay_cfg = 3;
    d = DW'($urandom);
    push_job(d);
    wait_resps(rc + 2, 40);
    check("t3_next_data", last_data, f_acc(d));
    check("t3_next_timeout", last_to, 0);
    tick(2);

    // Done on the last WAIT cycle still wins; one cycle later is a timeout.
    acc_delay_cfg = TO;
    rc = resp_cnt; t0 = cyc;
    d = DW'($urandom);
    push_job(d);
    wait_resps(rc + 1, 40);
    check("t4_edge_cyc", last_resp_cyc - t0, TO + 3);
    check("t4_edge_timeout", last_to, 0);
    check("t4_edge_data", last_data, f_acc(d));
    tick(4);
    acc_delay_cfg = TO + 1;
    rc = resp_cnt; t0 = cyc;
    push_job(DW'($urandom));
    wait_resps(rc + 1, 40);
    check("t4_late_cyc", last_resp_cyc - t0, TO + 3);
    check("t4_late_timeout", last_to, 1);
    tick(4);

    // Downstream stall in RESP: response holds, no new start, FIFO fills.
    ready_fixed = 1'b0;
    acc_delay_cfg = 2;
    rc = resp_cnt; sc = start_cnt;
    d = DW'($urandom);
    push_job(d);
    for (int i = 0; i < 40 && !out_valid; i++) tick();
    check("t5_valid", out_valid, 1);
    for (int i = 0; i < 4; i++) push_job(DW'($urandom));
    @(negedge clk);
    check("t5_full_ready", in_ready, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t5_hold", {acc_start, out_valid, out_timeout, out_data}, {1'b0, 1'b1, 1'b0, f_acc(d)});
      tick();
    end
    check("t5_starts", start_cnt - sc, 1);
    ready_fixed = 1'b1;
    wait_resps(rc + 5, 300);
    tick(2);

    // Reset mid-WAIT with two jobs still queued.
    acc_delay_cfg = 0;
    for (int i = 0; i < 3; i++) push_job(DW'($urandom));
    tick(2);
    check("t6_pre_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("t6_rst_ctrl", {acc_start, out_valid, out_timeout, busy}, 0);
    check("t6_rst_acc_data", acc_data, 0);
    check("t6_rst_out_data", out_data, 0);
    check("t6_rst_in_ready", in_ready, 1);
    exp_ops.delete();
    exp_resp.delete();
    cd = 0;
    tick(2);
    rst = 1'b0;
    sc = start_cnt; rc = resp_cnt;
    tick(20);
    check("t6_no_start", start_cnt - sc, 0);
    check("t6_no_resp", resp_cnt - rc, 0);
    check("t6_idle", busy, 0);
    acc_delay_cfg = 4;
    d = DW'($urandom);
    push_job(d);
    wait_resps(rc + 1, 40);
    check("t6_after_data", last_data, f_acc(d));
    tick(2);

    // Randomized stream: random gaps, delays and downstream ready.
    rand_ready = 1'b1;
    acc_delay_cfg = -1;
    rc = resp_cnt;
    for (int i = 0; i < 40; i++) begin
      tick($urandom_range(0, 3));
      push_job(DW'($urandom));
    end
    wait_resps(rc + 40, 3000);
    rand_ready = 1'b0;
    ready_fixed = 1'b1;
    tick(20);
    check("end_queues_empty", exp_resp.size() + exp_ops.size(), 0);
    check("end_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
